alu_control: RTL and testbench

- ALU control decoder for the 32-bit single-cycle MIPS datapath. Sits between the main control unit (3-bit ALUop) and the ALU (3-bit alu_ctr).
- Uses the instruction function field only for R-type instructions (ALUop=111).
- Output is registered, with one clock of latency, plus an illegal-function flag.

---
 rtl/alu_control_pkg.sv | 44 ++++
 rtl/alu_control_if.sv | 25 ++
 rtl/alu_control_decode.sv | 51 +++++
 rtl/alu_control.sv | 39 +++
 tb/tb_alu_control.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/alu_control_pkg.sv
// alu_pkg: shared encodings for the MIPS ALU control decoder.
//   ALUOP_*  operation class driven by the main control unit
//   CTR_*    operation select presented to the ALU
//   FUNCT_*  supported R-type funct field values
// The package has no ports.
package alu_pkg;

    // Operation classes from the main control unit.
    localparam logic [2:0] ALUOP_ADD   = 3'b000;  // lw/sw/addi
    localparam logic [2:0] ALUOP_SUB   = 3'b001;  // beq/bne
    localparam logic [2:0] ALUOP_AND   = 3'b010;  // andi
    localparam logic [2:0] ALUOP_OR    = 3'b011;  // ori
    localparam logic [2:0] ALUOP_SLT   = 3'b100;  // slti
    localparam logic [2:0] ALUOP_XOR   = 3'b101;  // xori
    localparam logic [2:0] ALUOP_NOR   = 3'b110;
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;

    // ALU operation selects.
    localparam logic [2:0] CTR_AND = 3'b000;
    localparam logic [2:0] CTR_OR  = 3'b001;
    localparam logic [2:0] CTR_ADD = 3'b010;
    localparam logic [2:0] CTR_XOR = 3'b011;
    localparam logic [2:0] CTR_NOR = 3'b100;
    localparam logic [2:0] CTR_SLT = 3'b101;
    localparam logic [2:0] CTR_SUB = 3'b110;
    localparam logic [2:0] CTR_SLL = 3'b111;

    // Supported R-type funct values. Their low three bits equal the
    // matching CTR_* code, which is what makes the R-type decode a pass-through.
    localparam logic [5:0] FUNCT_AND = 6'b000000;
    localparam logic [5:0] FUNCT_OR  = 6'b000001;
    localparam logic [5:0] FUNCT_ADD = 6'b000010;
    localparam logic [5:0] FUNCT_XOR = 6'b000011;
    localparam logic [5:0] FUNCT_NOR = 6'b000100;
    localparam logic [5:0] FUNCT_SLT = 6'b000101;
    localparam logic [5:0] FUNCT_SUB = 6'b000110;
    localparam logic [5:0] FUNCT_SLL = 6'b000111;

    // A funct value is supported only when its upper three bits are zero.
    function automatic logic funct_is_legal(input logic [5:0] funct);
        return (funct[5:3] == 3'b000);
    endfunction

endpackage

// File: rtl/alu_control_if.sv
// alu_control_if: bundles the decoder's control inputs and registered outputs.
//   function_code  instruction funct field [5:0]  (master -> slave)
//   ALUop          operation class from main control (master -> slave)
//   alu_ctr        registered ALU operation select (slave -> master)
//   illegal        registered unsupported-funct flag (slave -> master)
interface alu_control_if;
    logic [5:0] function_code;
    logic [2:0] ALUop;
    logic [2:0] alu_ctr;
    logic       illegal;

    modport master (
        output function_code,
        output ALUop,
        input  alu_ctr,
        input  illegal
    );

    modport slave (
        input  function_code,
        input  ALUop,
        output alu_ctr,
        output illegal
    );
endinterface

// File: rtl/alu_control_decode.sv
// alu_control_decode: combinational mapping of ALUop/function_code to the
// next ALU select and illegal flag.
//   alu_op_i     operation class
//   funct_i      R-type funct field (only used when alu_op_i is R-type)
//   alu_ctr_d_o  next ALU operation select
//   illegal_d_o  next illegal-funct flag
module alu_control_decode
    import alu_pkg::*;
(
    input  logic [2:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctr_d_o,
    output logic       illegal_d_o
);

    logic [2:0] ctr_s;
    logic       illegal_s;

    // Decode the operation class; R-type passes funct[2:0] through when legal.
    always_comb begin
        ctr_s     = CTR_ADD;
        illegal_s = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: ctr_s = CTR_ADD;
            ALUOP_SUB: ctr_s = CTR_SUB;
            ALUOP_AND: ctr_s = CTR_AND;
            ALUOP_OR:  ctr_s = CTR_OR;
            ALUOP_SLT: ctr_s = CTR_SLT;
            ALUOP_XOR: ctr_s = CTR_XOR;
            ALUOP_NOR: ctr_s = CTR_NOR;
            ALUOP_RTYPE: begin
                if (funct_is_legal(funct_i)) begin
                    ctr_s     = funct_i[2:0];
                    illegal_s = 1'b0;
                end else begin
                    // Unsupported funct: ADD is harmless, the flag reports it.
                    ctr_s     = CTR_ADD;
                    illegal_s = 1'b1;
                end
            end
            default: begin
                ctr_s     = CTR_ADD;
                illegal_s = 1'b0;
            end
        endcase
    end

    assign alu_ctr_d_o = ctr_s;
    assign illegal_d_o = illegal_s;

endmodule

// File: rtl/alu_control.sv
// alu_control: ALU control decoder with registered outputs (1-cycle latency).
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (alu_ctr=AND, illegal=0)
//   bus    alu_control_if.slave: function_code/ALUop in, alu_ctr/illegal out
module alu_control
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    alu_control_if.slave  bus
);

    logic [2:0] alu_ctr_d;
    logic       illegal_d;
    logic [2:0] alu_ctr_q;
    logic       illegal_q;

    alu_control_decode u_decode (
        .alu_op_i    (bus.ALUop),
        .funct_i     (bus.function_code),
        .alu_ctr_d_o (alu_ctr_d),
        .illegal_d_o (illegal_d)
    );

    // Output register: load the decode every edge, clear asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctr_q <= CTR_AND;
            illegal_q <= 1'b0;
        end else begin
            alu_ctr_q <= alu_ctr_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.alu_ctr = alu_ctr_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: table-driven directed test of alu_control plus hand-written
// reset, latency and asynchronous-reset sequences.
module tb_alu_control;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_control_if bus_if ();

    alu_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [5:0] fc;
        logic [2:0] ctr;
        logic       ill;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, then sample just after the next rising edge.
    task automatic apply(input logic [2:0] op, input logic [5:0] fc);
        @(negedge clk);
        bus_if.ALUop         = op;
        bus_if.function_code = fc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Non-R sweep (function_code ignored), R-type legal, R-type illegal then legal.
        vecs[0]  = '{3'b000, 6'b000000, 3'b010, 1'b0};
        vecs[1]  = '{3'b001, 6'b000000, 3'b110, 1'b0};
        vecs[2]  = '{3'b010, 6'b000000, 3'b000, 1'b0};
        vecs[3]  = '{3'b011, 6'b000000, 3'b001, 1'b0};
        vecs[4]  = '{3'b100, 6'b000000, 3'b101, 1'b0};
        vecs[5]  = '{3'b101, 6'b000000, 3'b011, 1'b0};
        vecs[6]  = '{3'b110, 6'b000000, 3'b100, 1'b0};
        vecs[7]  = '{3'b111, 6'b000010, 3'b010, 1'b0};
        vecs[8]  = '{3'b111, 6'b000101, 3'b101, 1'b0};
        vecs[9]  = '{3'b111, 6'b000011, 3'b011, 1'b0};
        vecs[10] = '{3'b111, 6'b000111, 3'b111, 1'b0};
        vecs[11] = '{3'b111, 6'b100000, 3'b010, 1'b1};
        vecs[12] = '{3'b111, 6'b000110, 3'b110, 1'b0};

        // Reset held with ALUop=SUB: outputs stay at AND/0 across edges.
        rst_n                = 1'b0;
        bus_if.ALUop         = 3'b001;
        bus_if.function_code = 6'b000000;
        repeat (3) @(posedge clk);
        #1;
        check3("reset_ctr", bus_if.alu_ctr, 3'b000);
        check1("reset_ill", bus_if.illegal, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check3("post_reset_ctr", bus_if.alu_ctr, 3'b110);
        check1("post_reset_ill", bus_if.illegal, 1'b0);

        // Table vectors, one per cycle.
        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].op, vecs[i].fc);
            check3($sformatf("vec%0d_ctr", i), bus_if.alu_ctr, vecs[i].ctr);
            check1($sformatf("vec%0d_ill", i), bus_if.illegal, vecs[i].ill);
        end

        // Every upper-bits-nonzero funct is illegal; sample one more corner.
        apply(ALUOP_RTYPE, 6'b111111);
        check3("funct3f_ctr", bus_if.alu_ctr, 3'b010);
        check1("funct3f_ill", bus_if.illegal, 1'b1);
        // Non-R class ignores a would-be-illegal funct.
        apply(ALUOP_NOR, 6'b111111);
        check3("nor_ignfc_ctr", bus_if.alu_ctr, 3'b100);
        check1("nor_ignfc_ill", bus_if.illegal, 1'b0);

        // Latency/hold: a mid-cycle input change is invisible until the next edge.
        apply(ALUOP_ADD, 6'b000000);
        check3("hold_before_ctr", bus_if.alu_ctr, 3'b010);
        #2;
        bus_if.ALUop = ALUOP_SUB;
        #1;
        check3("hold_mid_ctr", bus_if.alu_ctr, 3'b010);
        @(negedge clk);
        check3("hold_neg_ctr", bus_if.alu_ctr, 3'b010);
        @(posedge clk);
        #1;
        check3("hold_after_ctr", bus_if.alu_ctr, 3'b110);

        // Asynchronous reset pulse between edges.
        apply(ALUOP_RTYPE, FUNCT_SLL);
        check3("async_pre_ctr", bus_if.alu_ctr, 3'b111);
        #1;
        rst_n = 1'b0;
        #1;
        check3("async_now_ctr", bus_if.alu_ctr, 3'b000);
        check1("async_now_ill", bus_if.illegal, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check3("async_released_hold", bus_if.alu_ctr, 3'b000);
        @(posedge clk);
        #1;
        check3("async_post_ctr", bus_if.alu_ctr, 3'b111);
        check1("async_post_ill", bus_if.illegal, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
